// File: rtl/store_buffer_pkg.sv
// Shared types and constants for the store buffer: DM write-size encodings,
// default depth and the layout of one buffered store.
package store_buffer_pkg;

  // Project-wide default number of buffered stores.
  localparam int SB_DEPTH = 4;

  // Data-memory access sizes, matching the core's existing encodings.
  localparam logic [2:0] DM_w = 3'd0;
  localparam logic [2:0] DM_h = 3'd1;
  localparam logic [2:0] DM_b = 3'd2;

  // One posted write as held in the buffer.
  typedef struct packed {
    logic [31:0] addr;
    logic [31:0] wdata;
    logic [2:0]  op;
    logic [31:0] pc;
    logic [31:0] instr;
  } sb_entry_t;

  // Loads and buffered stores conflict when they touch the same 32-bit word.
  function automatic logic word_match(input logic [31:0] a, input logic [31:0] b);
    return a[31:2] == b[31:2];
  endfunction

endpackage

// File: rtl/store_buffer_if.sv
// Bus bundle between the MEM stage, the store buffer and the DM write port.
// The master side is the pipeline/memory environment, the slave side is the buffer.
interface store_buffer_if
  import store_buffer_pkg::*;
#(
  parameter int DEPTH = SB_DEPTH,
  parameter int CW    = $clog2(DEPTH + 1)
);

  logic          st_valid;
  logic [31:0]   st_addr;
  logic [31:0]   st_wdata;
  logic [2:0]    st_op;
  logic [31:0]   st_pc;
  logic [31:0]   st_instr;
  logic          st_ready;

  logic          ld_valid;
  logic [31:0]   ld_addr;
  logic          ld_stall;

  logic          dm_wr;
  logic [31:0]   dm_addr;
  logic [31:0]   dm_wd;
  logic [2:0]    dm_op;
  logic [31:0]   dm_pc;
  logic [31:0]   dm_instr;

  logic          sb_empty;
  logic [CW-1:0] sb_count;

  modport master (
    output st_valid, st_addr, st_wdata, st_op, st_pc, st_instr,
    output ld_valid, ld_addr,
    input  st_ready, ld_stall,
    input  dm_wr, dm_addr, dm_wd, dm_op, dm_pc, dm_instr,
    input  sb_empty, sb_count
  );

  modport slave (
    input  st_valid, st_addr, st_wdata, st_op, st_pc, st_instr,
    input  ld_valid, ld_addr,
    output st_ready, ld_stall,
    output dm_wr, dm_addr, dm_wd, dm_op, dm_pc, dm_instr,
    output sb_empty, sb_count
  );

endinterface

// File: rtl/store_buffer_sb_fifo.sv
// Circular in-order FIFO of buffered stores. Exposes the head entry plus a
// per-slot valid flag and address so the parent can run overlap comparators
// against every occupied slot.
module sb_fifo
  import store_buffer_pkg::*;
#(
  parameter int DEPTH = SB_DEPTH,
  parameter int CW    = $clog2(DEPTH + 1)
) (
  input  logic                   clk,
  input  logic                   reset,
  input  logic                   push_i,
  input  sb_entry_t              push_entry_i,
  input  logic                   pop_i,
  output sb_entry_t              head_o,
  output logic [CW-1:0]          count_o,
  output logic                   full_o,
  output logic                   empty_o,
  output logic [DEPTH-1:0]       vld_o,
  output logic [DEPTH-1:0][31:0] addr_o
);

  localparam int PW = $clog2(DEPTH);

  sb_entry_t        mem_q [DEPTH];
  logic [PW-1:0]    head_q, head_d;
  logic [PW-1:0]    tail_q, tail_d;
  logic [CW-1:0]    count_q, count_d;
  logic [DEPTH-1:0] vld_q, vld_d;
  logic             do_push, do_pop;

  assign full_o  = (count_q == CW'(DEPTH));
  assign empty_o = (count_q == '0);
  assign do_push = push_i && !full_o;
  assign do_pop  = pop_i && !empty_o;

  // Next pointers, occupancy and slot flags; DEPTH is a power of two so pointers wrap naturally.
  always_comb begin
    head_d  = head_q;
    tail_d  = tail_q;
    count_d = count_q;
    vld_d   = vld_q;
    if (do_pop) begin
      head_d        = head_q + 1'b1;
      vld_d[head_q] = 1'b0;
    end
    if (do_push) begin
      tail_d        = tail_q + 1'b1;
      vld_d[tail_q] = 1'b1;
    end
    case ({do_push, do_pop})
      2'b10:   count_d = count_q + 1'b1;
      2'b01:   count_d = count_q - 1'b1;
      default: count_d = count_q;
    endcase
  end

  // Control state; reset drops every buffered store.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      head_q  <= '0;
      tail_q  <= '0;
      count_q <= '0;
      vld_q   <= '0;
    end else begin
      head_q  <= head_d;
      tail_q  <= tail_d;
      count_q <= count_d;
      vld_q   <= vld_d;
    end
  end

  // Entry payload storage; contents are only observed through the valid flags.
  always_ff @(posedge clk) begin
    if (do_push) mem_q[tail_q] <= push_entry_i;
  end

  // Per-slot addresses for the overlap comparators.
  always_comb begin
    for (int i = 0; i < DEPTH; i++) addr_o[i] = mem_q[i].addr;
  end

  assign head_o  = mem_q[head_q];
  assign count_o = count_q;
  assign vld_o   = vld_q;

endmodule

// File: rtl/store_buffer.sv
// Posted-write buffer between the MEM stage and the data memory. Stores are
// accepted in one cycle, drained in order whenever the DM port is not taken by
// a load, and loads touching a buffered word stall until it has drained.
module store_buffer
  import store_buffer_pkg::*;
#(
  parameter int DEPTH = SB_DEPTH,
  parameter int CW    = $clog2(DEPTH + 1)
) (
  input  logic         clk,
  input  logic         reset,
  store_buffer_if.slave bus
);

  sb_entry_t              push_entry;
  sb_entry_t              head;
  logic                   push, pop, full, empty;
  logic [CW-1:0]          count;
  logic [DEPTH-1:0]       vld;
  logic [DEPTH-1:0][31:0] addrs;
  logic [DEPTH-1:0]       hit;
  logic                   stall;

  assign push_entry = '{addr:  bus.st_addr,  wdata: bus.st_wdata, op: bus.st_op,
                        pc:    bus.st_pc,    instr: bus.st_instr};
  assign push = bus.st_valid && !full;

  sb_fifo #(.DEPTH(DEPTH), .CW(CW)) u_fifo (
    .clk          (clk),
    .reset        (reset),
    .push_i       (push),
    .push_entry_i (push_entry),
    .pop_i        (pop),
    .head_o       (head),
    .count_o      (count),
    .full_o       (full),
    .empty_o      (empty),
    .vld_o        (vld),
    .addr_o       (addrs)
  );

  // Word-granular overlap check of the current load against every buffered store.
  always_comb begin
    hit = '0;
    for (int i = 0; i < DEPTH; i++) hit[i] = vld[i] && word_match(addrs[i], bus.ld_addr);
  end

  assign stall = bus.ld_valid && (|hit);

  // The DM port is free when no load uses it, or when the load is stalled anyway.
  assign pop = !empty && (!bus.ld_valid || stall);

  assign bus.st_ready = !full;
  assign bus.ld_stall = stall;
  assign bus.dm_wr    = pop;
  assign bus.dm_addr  = empty ? 32'd0 : head.addr;
  assign bus.dm_wd    = empty ? 32'd0 : head.wdata;
  assign bus.dm_op    = empty ? 3'd0  : head.op;
  assign bus.dm_pc    = empty ? 32'd0 : head.pc;
  assign bus.dm_instr = empty ? 32'd0 : head.instr;
  assign bus.sb_empty = empty;
  assign bus.sb_count = count;

endmodule
